// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and register-control outputs exchanged between the
// pipeline datapath (master) and the stall/flush controller (slave).
interface pipeline_ctrl_if;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic       rs1_used_d;
    logic       rs2_used_d;
    logic [4:0] rd_e;
    logic       mem_read_e;
    logic       mcyc_start_e;
    logic       redirect_e;
    logic       dmem_req_m;
    logic       dmem_ready_m;
    logic       imem_ready;

    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
    logic       mcyc_busy;

    modport master (
        output rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_e,
        output mem_read_e, mcyc_start_e, redirect_e,
        output dmem_req_m, dmem_ready_m, imem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        input  mcyc_busy
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_e,
        input  mem_read_e, mcyc_start_e, redirect_e,
        input  dmem_req_m, dmem_ready_m, imem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        output mcyc_busy
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: fixed-priority
// hazard resolution, multi-cycle EX sequencing and a front-end stall counter.
module pipeline_ctrl #(
    parameter int MulLatency = 4,
    parameter int CntWidth   = 16
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_ctrl_if.slave      bus,
    output logic [CntWidth-1:0] stall_count
);

    localparam int CW = $clog2(MulLatency) + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam bit MULTI = (MulLatency > 1);
    localparam logic [CW-1:0] CNT_INIT =
        MULTI ? CW'(MulLatency - 2) : '0;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          mem_stall;
    logic          load_use;
    logic          rs1_hit;
    logic          rs2_hit;
    logic          busy;
    logic [4:0]    en;
    logic [3:0]    fl;

    assign mem_stall = bus.dmem_req_m & ~bus.dmem_ready_m;
    assign rs1_hit   = bus.rs1_used_d & (bus.rs1_d == bus.rd_e);
    assign rs2_hit   = bus.rs2_used_d & (bus.rs2_d == bus.rd_e);
    assign load_use  = bus.mem_read_e & (bus.rd_e != 5'd0)
                     & (rs1_hit | rs2_hit);

    always_comb begin
        busy = 1'b0;
        if (!reset && MULTI) begin
            if (state == IDLE)
                busy = bus.mcyc_start_e & ~mem_stall;
            else
                busy = (cnt != '0) & ~mem_stall;
        end
    end

    // en = {pc, if_id, id_ex, ex_mem, mem_wb}, fl = {if_id, id_ex, ex_mem, mem_wb}
    always_comb begin
        en = 5'b11111;
        fl = 4'b0000;
        if (reset) begin
            en = 5'b00000;
        end else if (mem_stall) begin
            en = 5'b00001;
            fl = 4'b0001;
        end else if (busy) begin
            en = 5'b00011;
            fl = 4'b0010;
        end else if (bus.redirect_e) begin
            fl = 4'b1100;
        end else if (load_use) begin
            en = 5'b00111;
            fl = 4'b0100;
        end else if (!bus.imem_ready) begin
            en = 5'b01111;
            fl = 4'b1000;
        end
    end

    assign bus.pc_en        = en[4];
    assign bus.if_id_en     = en[3];
    assign bus.id_ex_en     = en[2];
    assign bus.ex_mem_en    = en[1];
    assign bus.mem_wb_en    = en[0];
    assign bus.if_id_flush  = fl[3];
    assign bus.id_ex_flush  = fl[2];
    assign bus.ex_mem_flush = fl[1];
    assign bus.mem_wb_flush = fl[0];
    assign bus.mcyc_busy    = busy;

    // A memory stall freezes the sequence; cnt==0 in BUSY releases the op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (busy) begin
                state <= BUSY;
                cnt   <= CNT_INIT;
            end
        end else if (!mem_stall) begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            else
                state <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (!en[4] && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level reference model
// and a saturating-counter companion instance (CntWidth=2).
module tb_pipeline_ctrl;
    localparam int ML = 4;

    logic        clk;
    logic        reset;
    logic [15:0] stall_count;
    logic [1:0]  sat_count;

    pipeline_ctrl_if bus ();
    pipeline_ctrl_if bus2 ();

    pipeline_ctrl #(.MulLatency(ML), .CntWidth(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .stall_count(stall_count)
    );

    pipeline_ctrl #(.MulLatency(ML), .CntWidth(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2), .stall_count(sat_count)
    );

    assign bus2.rs1_d        = bus.rs1_d;
    assign bus2.rs2_d        = bus.rs2_d;
    assign bus2.rs1_used_d   = bus.rs1_used_d;
    assign bus2.rs2_used_d   = bus.rs2_used_d;
    assign bus2.rd_e         = bus.rd_e;
    assign bus2.mem_read_e   = bus.mem_read_e;
    assign bus2.mcyc_start_e = bus.mcyc_start_e;
    assign bus2.redirect_e   = bus.redirect_e;
    assign bus2.dmem_req_m   = bus.dmem_req_m;
    assign bus2.dmem_ready_m = bus.dmem_ready_m;
    assign bus2.imem_ready   = bus.imem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model state: non-stalled EX cycles spent by the current multi-cycle op.
    int mdone  = 0;
    int cnt_m  = 0;
    int sat_m  = 0;

    logic       ms, mb, lu;
    logic [9:0] exp_vec;
    logic [9:0] dut_vec;

    assign dut_vec = {bus.pc_en, bus.if_id_en, bus.id_ex_en,
                      bus.ex_mem_en, bus.mem_wb_en,
                      bus.if_id_flush, bus.id_ex_flush,
                      bus.ex_mem_flush, bus.mem_wb_flush, bus.mcyc_busy};

    always_comb begin
        ms = bus.dmem_req_m && !bus.dmem_ready_m;
        mb = bus.mcyc_start_e && !ms && (mdone < ML - 1);
        lu = bus.mem_read_e && (bus.rd_e != 5'd0) &&
             ((bus.rs1_used_d && bus.rs1_d == bus.rd_e) ||
              (bus.rs2_used_d && bus.rs2_d == bus.rd_e));
        exp_vec = 10'b11111_0000_0;
        if (reset)                exp_vec = 10'b00000_0000_0;
        else if (ms)              exp_vec = 10'b00001_0001_0;
        else if (mb)              exp_vec = 10'b00011_0010_1;
        else if (bus.redirect_e)  exp_vec = 10'b11111_1100_0;
        else if (lu)              exp_vec = 10'b00111_0100_0;
        else if (!bus.imem_ready) exp_vec = 10'b01111_1000_0;
    end

    always @(posedge clk) begin
        if (reset) begin
            mdone = 0;
            cnt_m = 0;
            sat_m = 0;
        end else begin
            if (!exp_vec[9]) begin
                if (cnt_m != 65535) cnt_m = cnt_m + 1;
                if (sat_m != 3) sat_m = sat_m + 1;
            end
            if (bus.mcyc_start_e && !ms)
                mdone = (mdone == ML - 1) ? 0 : mdone + 1;
            else if (!bus.mcyc_start_e)
                mdone = 0;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s act=%0d req=%0d at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        checks++;
        if (dut_vec === exp_vec) passes++;
        else $display("FAIL ctl act=%b req=%b at %0t", dut_vec, exp_vec, $time);
        chk("model_count", int'(stall_count), reset ? 0 : cnt_m);
        chk("model_sat", int'(sat_count), reset ? 0 : sat_m);
    end

    task automatic defaults();
        bus.rs1_d = 5'd0;
        bus.rs2_d = 5'd0;
        bus.rs1_used_d = 1'b0;
        bus.rs2_used_d = 1'b0;
        bus.rd_e = 5'd0;
        bus.mem_read_e = 1'b0;
        bus.mcyc_start_e = 1'b0;
        bus.redirect_e = 1'b0;
        bus.dmem_req_m = 1'b0;
        bus.dmem_ready_m = 1'b0;
        bus.imem_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        bus.mem_read_e = 1'b1;
        bus.rd_e = 5'd5;
        bus.rs1_d = 5'd5;
        bus.rs1_used_d = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        defaults();
        bus.mcyc_start_e = 1'b1;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        chk("reset_vec", int'(dut_vec), 0);
        chk("reset_count", int'(stall_count), 0);

        next_cycle();
        reset = 1'b0;
        defaults();
        @(negedge clk);
        chk("idle_vec", int'(dut_vec), 10'b11111_0000_0);

        // load-use hazard
        next_cycle();
        set_load_use();
        @(negedge clk);
        chk("lu_pc_en", int'(bus.pc_en), 0);
        chk("lu_if_id_en", int'(bus.if_id_en), 0);
        chk("lu_id_ex_flush", int'(bus.id_ex_flush), 1);
        next_cycle();
        defaults();
        @(negedge clk);
        chk("lu_count", int'(stall_count), 1);

        // same pattern targeting x0
        next_cycle();
        set_load_use();
        bus.rd_e = 5'd0;
        bus.rs1_d = 5'd0;
        @(negedge clk);
        chk("x0_pc_en", int'(bus.pc_en), 1);
        chk("x0_id_ex_flush", int'(bus.id_ex_flush), 0);

        // multi-cycle op
        next_cycle();
        defaults();
        bus.mcyc_start_e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mc_busy", int'(bus.mcyc_busy), (i < 3) ? 1 : 0);
            chk("mc_pc_en", int'(bus.pc_en), (i == 3) ? 1 : 0);
            chk("mc_ex_mem_flush", int'(bus.ex_mem_flush), (i < 3) ? 1 : 0);
            next_cycle();
        end
        bus.mcyc_start_e = 1'b0;
        @(negedge clk);
        chk("mc_count", int'(stall_count), 4);

        // memory stall inside a BUSY sequence
        next_cycle();
        bus.mcyc_start_e = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.dmem_req_m = (i == 1 || i == 2);
            @(negedge clk);
            chk("ms_busy", int'(bus.mcyc_busy),
                (i == 0 || i == 3 || i == 4) ? 1 : 0);
            chk("ms_mem_wb_flush", int'(bus.mem_wb_flush),
                (i == 1 || i == 2) ? 1 : 0);
            chk("ms_pc_en", int'(bus.pc_en), (i == 5) ? 1 : 0);
            next_cycle();
        end
        defaults();
        @(negedge clk);
        chk("ms_count", int'(stall_count), 9);

        // redirect beats load-use and fetch wait
        next_cycle();
        set_load_use();
        bus.redirect_e = 1'b1;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        chk("rd_if_id_flush", int'(bus.if_id_flush), 1);
        chk("rd_id_ex_flush", int'(bus.id_ex_flush), 1);
        chk("rd_pc_en", int'(bus.pc_en), 1);
        next_cycle();
        bus.dmem_req_m = 1'b1;
        @(negedge clk);
        chk("rdms_pc_en", int'(bus.pc_en), 0);
        chk("rdms_mem_wb_flush", int'(bus.mem_wb_flush), 1);
        chk("rdms_if_id_flush", int'(bus.if_id_flush), 0);

        // fetch wait
        next_cycle();
        defaults();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fw_pc_en", int'(bus.pc_en), 0);
            chk("fw_if_id_flush", int'(bus.if_id_flush), 1);
            next_cycle();
        end
        defaults();
        @(negedge clk);
        chk("fw_count", int'(stall_count), 13);
        chk("fw_sat", int'(sat_count), 3);

        // reset in the middle of a BUSY sequence
        next_cycle();
        bus.mcyc_start_e = 1'b1;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_vec", int'(dut_vec), 0);
        chk("rst_count", int'(stall_count), 0);
        next_cycle();
        reset = 1'b0;
        bus.mcyc_start_e = 1'b0;
        @(negedge clk);
        chk("rel_vec", int'(dut_vec), 10'b11111_0000_0);

        // counter saturation
        next_cycle();
        bus.imem_ready = 1'b0;
        repeat (5) next_cycle();
        bus.imem_ready = 1'b1;
        @(negedge clk);
        chk("sat_count", int'(sat_count), 3);
        chk("sat_main", int'(stall_count), 5);

        repeat (2) next_cycle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
